fir_interp: RTL

FIR_INTERP -- requirements
Module: fir_interp

---
 rtl/fir_interp.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fir_interp.sv
// Polyphase FIR interpolator. Each input sample popped from the upstream
// FIFO yields INTERP output samples, one per phase. A phase takes K
// multiply-accumulate cycles followed by one write cycle.
module fir_interp #(
    parameter int NUM_TAPS  = 32,
    parameter int INTERP    = 8,
    parameter int DATA_SIZE = 32,
    parameter int BITS      = 10,
    parameter logic signed [0:NUM_TAPS-1][DATA_SIZE-1:0] COEFFICIENTS = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        x_in_empty,
    output logic                        x_in_rd_en,
    input  logic signed [DATA_SIZE-1:0] x_in_dout,
    input  logic                        y_out_full,
    output logic                        y_out_wr_en,
    output logic signed [DATA_SIZE-1:0] y_out_din
);

    localparam int K   = NUM_TAPS / INTERP;
    localparam int K_W = (K > 1) ? $clog2(K) : 1;
    localparam int P_W = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam int T_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    localparam logic [1:0] S_READ  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic [P_W-1:0] P_LAST = P_W'(INTERP - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(K - 1);

    logic [1:0]                          state_q, state_d;
    logic [P_W-1:0]                      p_q, p_d;
    logic [K_W-1:0]                      k_q, k_d;
    logic signed [DATA_SIZE-1:0]         acc_q, acc_d;
    logic [K-1:0][DATA_SIZE-1:0]         hist_q, hist_d;
    logic [T_W-1:0]                      tap_idx;

    // Full-precision product, arithmetic shift to dequantize, then keep the
    // low DATA_SIZE bits (the running sum wraps rather than saturates).
    function automatic logic signed [DATA_SIZE-1:0] mac_term(
        input logic signed [DATA_SIZE-1:0] h,
        input logic signed [DATA_SIZE-1:0] x
    );
        logic signed [2*DATA_SIZE-1:0] prod;
        prod = (2*DATA_SIZE)'(h) * (2*DATA_SIZE)'(x);
        prod = prod >>> BITS;
        return prod[DATA_SIZE-1:0];
    endfunction

    // Phase p, history slot k uses tap h[p + k*INTERP].
    assign tap_idx   = T_W'(k_q) * T_W'(INTERP) + T_W'(p_q);

    // The accumulator is stable throughout S_WRITE, so it drives the output.
    assign y_out_din = acc_q;

    // Next-state, datapath update and FIFO handshakes.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        k_d         = k_q;
        acc_d       = acc_q;
        hist_d      = hist_q;
        x_in_rd_en  = 1'b0;
        y_out_wr_en = 1'b0;
        case (state_q)
            S_READ: begin
                if (!x_in_empty) begin
                    // Gated by reset so no pop is signalled while held in reset.
                    x_in_rd_en = reset;
                    hist_d[0]  = x_in_dout;
                    for (int i = 1; i < K; i++) begin
                        hist_d[i] = hist_q[i-1];
                    end
                    p_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + mac_term($signed(COEFFICIENTS[tap_idx]),
                                         $signed(hist_q[k_q]));
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_WRITE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_WRITE: begin
                if (!y_out_full) begin
                    y_out_wr_en = 1'b1;
                    if (p_q != P_LAST) begin
                        p_d     = p_q + P_W'(1);
                        acc_d   = '0;
                        state_d = S_MAC;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            default: state_d = S_READ;
        endcase
    end

    // State registers; reset abandons any partial output and clears history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_READ;
            p_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            hist_q  <= hist_d;
        end
    end

endmodule
